pipeline_stall_ctrl: RTL and testbench

//  Consumer side of the hazard-detection stall interface. Turns hazard-unit Stall, cache

---
 rtl/pipeline_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush/bubble controller for a 5-stage pipeline: cache freeze, hazard bubble, redirect replay.
// Optional perf counters enabled by defining PIPELINE_STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int MAX_HZ_CYC = 8,
  parameter int TO_W       = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             redirect,
  output logic             pc_we,
  output logic             pc_sel_redir,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             redir_pend,
  output logic             hz_timeout,
  output logic [CNT_W-1:0] stall_cyc_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HZ, S_MEM} state_t;

  localparam logic [TO_W-1:0] HZ_MAX = TO_W'(MAX_HZ_CYC);

  state_t          state, nxt;
  logic            mem, in_boot, redir_go;
  logic [TO_W-1:0] hz_cnt, hz_cnt_nxt;

  assign mem     = icache_stall | dcache_stall;
  assign in_boot = (state == S_BOOT);

  // Classification of the current cycle; also the next registered state.
  always_comb begin
    if (mem)           nxt = S_MEM;
    else if (hz_stall) nxt = S_HZ;
    else               nxt = S_RUN;
  end

  // Hazard cycles swallow a redirect pulse; only a latched one survives.
  assign redir_go = !in_boot && (nxt == S_RUN) && (redirect || redir_pend);

  always_comb begin
    pc_we        = 1'b1;
    pc_sel_redir = 1'b0;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b1;
    memwb_we     = 1'b1;
    if (in_boot) begin
      pc_we       = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (nxt == S_MEM) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (nxt == S_HZ) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (redir_go) begin
      pc_sel_redir = 1'b1;
      ifid_flush   = 1'b1;
    end
  end

  // Hazard run length: saturating, frozen across memory stalls.
  always_comb begin
    hz_cnt_nxt = '0;
    if (in_boot)            hz_cnt_nxt = '0;
    else if (nxt == S_MEM)  hz_cnt_nxt = hz_cnt;
    else if (nxt == S_HZ)   hz_cnt_nxt = (hz_cnt >= HZ_MAX) ? hz_cnt : hz_cnt + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BOOT;
      hz_cnt     <= '0;
      hz_timeout <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      state  <= nxt;
      hz_cnt <= hz_cnt_nxt;
      if (hz_cnt_nxt == HZ_MAX) hz_timeout <= 1'b1;
      if (!in_boot) begin
        if (nxt == S_MEM && redirect) redir_pend <= 1'b1;
        else if (redir_go)            redir_pend <= 1'b0;
      end
    end
  end

`ifdef PIPELINE_STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (!in_boot) begin
      if (nxt != S_RUN) stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush)   flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cyc_cnt = stall_q;
  assign flush_cnt     = flush_q;
`else
  assign stall_cyc_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: per-cycle reference model plus directed literal checks.
module tb_pipeline_stall_ctrl;
  localparam int MAX_HZ_CYC = 8;
  localparam int CNT_W      = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic hz_stall = 1'b0, icache_stall = 1'b0, dcache_stall = 1'b0, redirect = 1'b0;
  logic pc_we, pc_sel_redir, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
  logic redir_pend, hz_timeout;
  logic [CNT_W-1:0] stall_cyc_cnt, flush_cnt;

  int n_chk = 0, n_fail = 0;

  pipeline_stall_ctrl #(.MAX_HZ_CYC(MAX_HZ_CYC), .TO_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .icache_stall(icache_stall),
    .dcache_stall(dcache_stall), .redirect(redirect), .pc_we(pc_we),
    .pc_sel_redir(pc_sel_redir), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .redir_pend(redir_pend), .hz_timeout(hz_timeout), .stall_cyc_cnt(stall_cyc_cnt),
    .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-cycle view of the pipeline controller.
  bit           m_boot = 1'b1, m_pend = 1'b0, m_to = 1'b0;
  int           m_run = 0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1'b1; m_pend <= 1'b0; m_to <= 1'b0; m_run <= 0;
      m_stall <= '0; m_flush <= '0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (icache_stall || dcache_stall) begin
      m_stall <= m_stall + 1;
      if (redirect) m_pend <= 1'b1;
    end else if (hz_stall) begin
      m_stall <= m_stall + 1;
      m_run   <= m_run + 1;
      if (m_run + 1 >= MAX_HZ_CYC) m_to <= 1'b1;
    end else begin
      if (redirect || m_pend) begin
        m_flush <= m_flush + 1;
        m_pend  <= 1'b0;
      end
      m_run <= 0;
    end
  end

  // {pc_we, pc_sel_redir, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
  function automatic logic [7:0] exp_ctl();
    if (m_boot)                          return 8'b0011_1111;
    if (icache_stall || dcache_stall)    return 8'b0000_0000;
    if (hz_stall)                        return 8'b0000_1111;
    if (redirect || m_pend)              return 8'b1111_1011;
    return 8'b1010_1011;
  endfunction

  always @(negedge clk) begin
    chk("ctl", {pc_we, pc_sel_redir, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we},
        exp_ctl());
    chk("redir_pend", redir_pend, m_pend);
    chk("hz_timeout", hz_timeout, m_to);
`ifdef PIPELINE_STALL_PERF_CNT_EN
    chk("stall_cyc_cnt", stall_cyc_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`else
    chk("stall_cyc_cnt", stall_cyc_cnt, 0);
    chk("flush_cnt", flush_cnt, 0);
`endif
  end

  // Apply one cycle of inputs; returns at the negedge so outputs can be inspected.
  task automatic step(input logic h, input logic i, input logic d, input logic r);
    @(posedge clk); #1;
    hz_stall = h; icache_stall = i; dcache_stall = d; redirect = r;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic r_in_boot);
    @(posedge clk); #1;
    rst_n = 1'b0; {hz_stall, icache_stall, dcache_stall, redirect} = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; redirect = r_in_boot;
    @(negedge clk);
  endtask

  initial begin
    do_reset(1'b0);
    // BOOT cycle
    chk("boot_pc_we", pc_we, 0);
    chk("boot_flush", ifid_flush, 1);
    chk("boot_bubble", idex_bubble, 1);
    chk("boot_memwb_we", memwb_we, 1);
    chk("rst_pend", redir_pend, 0);
    chk("rst_to", hz_timeout, 0);
    step(0, 0, 0, 0);
    chk("run_pc_we", pc_we, 1);
    chk("run_flush", ifid_flush, 0);

    // 3-cycle hazard
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0);
      chk("hz_pc_we", pc_we, 0);
      chk("hz_ifid_we", ifid_we, 0);
      chk("hz_bubble", idex_bubble, 1);
      chk("hz_exmem_we", exmem_we, 1);
    end
    step(0, 0, 0, 0);
    chk("hz3_to", hz_timeout, 0);
    chk("hz3_release", {pc_we, idex_bubble}, 2'b10);

    // D-cache freeze with redirect in cycle 2
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("mem_pend_c2", redir_pend, 0);
    step(0, 0, 1, 0);
    chk("mem_pend_c3", redir_pend, 1);
    chk("mem_we_c3", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'b0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("replay_sel", pc_sel_redir, 1);
    chk("replay_flush", ifid_flush, 1);
    step(0, 0, 0, 0);
    chk("replay_pend_clr", redir_pend, 0);
    chk("replay_once", ifid_flush, 0);

    // Hazard + I-cache: freeze wins, then bubble
    step(1, 1, 0, 0);
    chk("hzmem_we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'b0);
    chk("hzmem_bubble", idex_bubble, 0);
    step(1, 0, 0, 0);
    chk("hz_after_mem_bubble", idex_bubble, 1);

    // Redirect during hazard is dropped
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("hz_redir_drop", pc_sel_redir, 0);

    // Redirect coincident with pending replay: one flush
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    chk("dual_flush", ifid_flush, 1);
    step(0, 0, 0, 0);
    chk("dual_no_second", ifid_flush, 0);

    // Hazard run clear then 8-cycle timeout
    repeat (7) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (7) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("hz7_no_to", hz_timeout, 0);
    repeat (8) step(1, 0, 0, 0);
    chk("hz8_not_yet", hz_timeout, 0);
    step(0, 0, 0, 0);
    chk("hz8_to", hz_timeout, 1);
    step(0, 0, 0, 0);
    chk("to_sticky", hz_timeout, 1);

    // Async reset during a freeze with a pending redirect
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("pre_rst_pend", redir_pend, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pend", redir_pend, 0);
    chk("async_to", hz_timeout, 0);
    do_reset(1'b1);   // redirect during BOOT must not latch
    step(0, 0, 0, 0);
    chk("boot_redir_ignored", {pc_sel_redir, redir_pend}, 2'b00);

    // Hazard count held across a freeze
    repeat (5) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("hold_to", hz_timeout, 1);

    // Perf counters from a fresh reset
    do_reset(1'b0);
    repeat (3) step(1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
`ifdef PIPELINE_STALL_PERF_CNT_EN
    chk("perf_stall", stall_cyc_cnt, 8);
    chk("perf_flush", flush_cnt, 2);
`else
    chk("perf_stall_off", stall_cyc_cnt, 0);
    chk("perf_flush_off", flush_cnt, 0);
`endif

    step(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
